tl_d_resp_checker: RTL and testbench
====================================

// Module: tl_d_resp_checker
// PURPOSE
//   Upstream feeder for the TileLink D-channel response assertion monitor. Tracks in-flight
//   A-channel requests per source ID and whether each expects data (Get vs Put/atomic ack).
//   On every D-channel beat it publishes one registered check vector:
//   skip, expected-data bit, actual-data bit, bypass. The monitor downstream fails when
//   !(skip | exp==act | bypass). Sits between the port's A/D fire logic and that monitor.
// PARAMETERS
//   SOURCE_BITS  2   width of a_source/d_source; tracker holds 2**SOURCE_BITS entries
//   CNT_BITS     3   width of inflight_cnt; must be >= SOURCE_BITS+1
// PORTS
//   clock          in   1             sole clock, all state updates on rising edge
//   reset          in   1             synchronous, active-high
//   a_fire         in   1             A-channel handshake (valid & ready) this cycle
//   a_source       in   SOURCE_BITS   source ID of A request
//   a_get          in   1             1 = request expects AccessAckData (Get)
//   d_fire         in   1             D-channel beat handshake this cycle
//   d_source       in   SOURCE_BITS   source ID of D beat
//   d_has_data     in   1             1 = D opcode carries data
//   d_last         in   1             final beat of D message
//   d_denied       in   1             response denied; check waived
//   chk_skip       out  1             1 = no D beat checked this cycle
//   chk_exp_data   out  1             expected data bit for checked beat
//   chk_act_data   out  1             actual d_has_data of checked beat
//   chk_bypass     out  1             1 = check waived this cycle
//   inflight       out  2**SOURCE_BITS  per-source busy mask
//   inflight_cnt   out  CNT_BITS      popcount of inflight
//   err_dup_src    out  1             sticky: A issued on already-busy source
//   err_unk_src    out  1             sticky: D beat on idle source
// BEHAVIOUR
//   Reset (sync, high): inflight=0, exp table=0, inflight_cnt=0, chk_skip=1, chk_exp_data=0,
//     chk_act_data=0, chk_bypass=1, err_*=0. chk_bypass is also 1 on the first cycle
//     after reset deasserts, then 0. Reset mid-transaction drops all tracking state.
//   Entry state per source: IDLE -> BUSY on a_fire; BUSY -> IDLE on d_fire & d_last.
//     Non-last beats leave the entry BUSY. exp[src] <= a_get on allocation.
//   Check pipeline: one-cycle latency. Cycle N d_fire -> cycle N+1 chk_skip=0,
//     chk_act_data=d_has_data(N), chk_exp_data=exp[d_source](N) read before N's update,
//     chk_bypass=d_denied(N). No d_fire -> chk_skip=1, other chk_* hold prior value.
//   Unknown source: d_fire on IDLE entry -> err_unk_src set, chk_exp_data = ~d_has_data
//     (forces downstream failure unless denied), entry stays IDLE.
//   Duplicate: a_fire on BUSY entry not released same cycle -> err_dup_src set; exp overwritten.
//   Same cycle, same source, D last-beat release + A allocate: legal, entry ends BUSY with
//     new exp; no error. Check uses the old exp.
//   Same cycle, different sources: both apply independently.
//   inflight_cnt: +1 on allocate of IDLE entry, -1 on release; net 0 when both.
//     Saturation impossible; all 2**SOURCE_BITS busy gives cnt=2**SOURCE_BITS.
//   Errors clear only on reset.
// TESTING
//   Reset then a_fire src1 a_get=1; 2 cycles later d_fire src1 has_data=1 last=1 ->
//     next cycle skip=0 exp=1 act=1 bypass=0; inflight=0, cnt=0.
//   Put src0 (a_get=0), D src0 has_data=1 -> exp=0 act=1 (monitor fails); err flags 0.
//   Get src2, 4-beat D with last on beat 4 -> 4 consecutive checks exp=1; inflight[2]
//     clears only after beat 4; cnt 1 -> 0 at beat-4 edge.
//   D src3 while idle -> err_unk_src=1, exp=~act; with d_denied=1 -> bypass=1.
//   Fill all 4 sources -> cnt=4; same-cycle D last src2 + A src2 -> cnt stays 4, no err;
//     second A src0 -> err_dup_src=1.
//   Assert reset mid-burst with 3 busy -> next cycle inflight=0, cnt=0, skip=1, bypass=1.

Source files
------------

// File: rtl/tl_d_resp_checker.sv
// Tracks in-flight TileLink A requests per source and emits a registered D-channel check
// vector (skip, expected data, actual data, bypass) for a downstream response monitor.
module tl_d_resp_checker #(
    parameter int unsigned SOURCE_BITS = 2,
    parameter int unsigned CNT_BITS    = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          a_fire,
    input  logic [SOURCE_BITS-1:0]        a_source,
    input  logic                          a_get,
    input  logic                          d_fire,
    input  logic [SOURCE_BITS-1:0]        d_source,
    input  logic                          d_has_data,
    input  logic                          d_last,
    input  logic                          d_denied,
    output logic                          chk_skip,
    output logic                          chk_exp_data,
    output logic                          chk_act_data,
    output logic                          chk_bypass,
    output logic [(1<<SOURCE_BITS)-1:0]   inflight,
    output logic [CNT_BITS-1:0]           inflight_cnt,
    output logic                          err_dup_src,
    output logic                          err_unk_src
);

    localparam int unsigned NUM_SRC = 1 << SOURCE_BITS;

    logic [NUM_SRC-1:0]  inflight_q, inflight_d;
    logic [NUM_SRC-1:0]  exp_q, exp_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                skip_q, skip_d;
    logic                exp_data_q, exp_data_d;
    logic                act_data_q, act_data_d;
    logic                bypass_q, bypass_d;
    logic                post_rst_q;
    logic                err_dup_q, err_dup_d;
    logic                err_unk_q, err_unk_d;

    logic d_busy, a_busy, rel, rel_same, alloc_new;

    // Tracker update and check-vector formation
    always_comb begin
        d_busy     = inflight_q[d_source];
        a_busy     = inflight_q[a_source];
        rel        = d_fire & d_busy & d_last;
        rel_same   = rel & (d_source == a_source);
        alloc_new  = a_fire & (~a_busy | rel_same);

        inflight_d = inflight_q;
        exp_d      = exp_q;
        skip_d     = ~d_fire;
        exp_data_d = exp_data_q;
        act_data_d = act_data_q;
        bypass_d   = bypass_q;

        // Release happens before allocate so a same-source pair ends busy with the new exp
        if (rel) begin
            inflight_d[d_source] = 1'b0;
        end
        if (a_fire) begin
            inflight_d[a_source] = 1'b1;
            exp_d[a_source]      = a_get;
        end

        cnt_d = cnt_q + CNT_BITS'(alloc_new) - CNT_BITS'(rel);

        err_dup_d = err_dup_q | (a_fire & a_busy & ~rel_same);
        err_unk_d = err_unk_q | (d_fire & ~d_busy);

        if (d_fire) begin
            act_data_d = d_has_data;
            exp_data_d = d_busy ? exp_q[d_source] : ~d_has_data;
            bypass_d   = d_denied;
        end else if (post_rst_q) begin
            bypass_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= '0;
            exp_q      <= '0;
            cnt_q      <= '0;
            skip_q     <= 1'b1;
            exp_data_q <= 1'b0;
            act_data_q <= 1'b0;
            bypass_q   <= 1'b1;
            post_rst_q <= 1'b1;
            err_dup_q  <= 1'b0;
            err_unk_q  <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            skip_q     <= skip_d;
            exp_data_q <= exp_data_d;
            act_data_q <= act_data_d;
            bypass_q   <= bypass_d;
            post_rst_q <= 1'b0;
            err_dup_q  <= err_dup_d;
            err_unk_q  <= err_unk_d;
        end
    end

    assign chk_skip     = skip_q;
    assign chk_exp_data = exp_data_q;
    assign chk_act_data = act_data_q;
    assign chk_bypass   = bypass_q;
    assign inflight     = inflight_q;
    assign inflight_cnt = cnt_q;
    assign err_dup_src  = err_dup_q;
    assign err_unk_src  = err_unk_q;

endmodule

// File: tb/tb_tl_d_resp_checker.sv
// Directed bench for tl_d_resp_checker: hand-computed expectations for tracker and check vector.
module tb_tl_d_resp_checker;

    logic       clock = 1'b0;
    logic       reset;
    logic       a_fire, a_get;
    logic [1:0] a_source;
    logic       d_fire, d_has_data, d_last, d_denied;
    logic [1:0] d_source;
    logic       chk_skip, chk_exp_data, chk_act_data, chk_bypass;
    logic [3:0] inflight;
    logic [2:0] inflight_cnt;
    logic       err_dup_src, err_unk_src;

    int n_cmp = 0;
    int n_err = 0;

    tl_d_resp_checker #(.SOURCE_BITS(2), .CNT_BITS(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .a_fire       (a_fire),
        .a_source     (a_source),
        .a_get        (a_get),
        .d_fire       (d_fire),
        .d_source     (d_source),
        .d_has_data   (d_has_data),
        .d_last       (d_last),
        .d_denied     (d_denied),
        .chk_skip     (chk_skip),
        .chk_exp_data (chk_exp_data),
        .chk_act_data (chk_act_data),
        .chk_bypass   (chk_bypass),
        .inflight     (inflight),
        .inflight_cnt (inflight_cnt),
        .err_dup_src  (err_dup_src),
        .err_unk_src  (err_unk_src)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic idle_inputs();
        a_fire = 0; a_source = 0; a_get = 0;
        d_fire = 0; d_source = 0; d_has_data = 0; d_last = 0; d_denied = 0;
    endtask

    // Advance one clock edge; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    task automatic drive_a(input logic [1:0] src, input logic get);
        a_fire = 1; a_source = src; a_get = get;
    endtask

    task automatic drive_d(input logic [1:0] src, input logic data, input logic last, input logic den);
        d_fire = 1; d_source = src; d_has_data = data; d_last = last; d_denied = den;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step();
        step();
        check_eq("rst_skip",     32'(chk_skip),     32'd1);
        check_eq("rst_bypass",   32'(chk_bypass),   32'd1);
        check_eq("rst_exp",      32'(chk_exp_data), 32'd0);
        check_eq("rst_act",      32'(chk_act_data), 32'd0);
        check_eq("rst_inflight", 32'(inflight),     32'h0);
        check_eq("rst_cnt",      32'(inflight_cnt), 32'd0);
        check_eq("rst_errs",     32'({err_dup_src, err_unk_src}), 32'd0);

        reset = 0;
        step();
        step();
        check_eq("post_rst_bypass", 32'(chk_bypass), 32'd0);
        check_eq("post_rst_skip",   32'(chk_skip),   32'd1);

        // Get on src1, response two cycles later
        drive_a(2'd1, 1'b1); step();
        check_eq("t1_inflight", 32'(inflight),     32'h2);
        check_eq("t1_cnt",      32'(inflight_cnt), 32'd1);
        step();
        drive_d(2'd1, 1'b1, 1'b1, 1'b0); step();
        check_eq("t1_chk", 32'({chk_skip, chk_exp_data, chk_act_data, chk_bypass}), 32'b0110);
        check_eq("t1_inflight_clr", 32'(inflight),     32'h0);
        check_eq("t1_cnt_clr",      32'(inflight_cnt), 32'd0);

        // Put on src0 answered with data: exp=0, act=1
        drive_a(2'd0, 1'b0); step();
        drive_d(2'd0, 1'b1, 1'b1, 1'b0); step();
        check_eq("t2_chk",  32'({chk_skip, chk_exp_data, chk_act_data, chk_bypass}), 32'b0010);
        check_eq("t2_errs", 32'({err_dup_src, err_unk_src}), 32'd0);

        // 4-beat Get burst on src2
        drive_a(2'd2, 1'b1); step();
        for (int b = 1; b <= 4; b++) begin
            drive_d(2'd2, 1'b1, (b == 4), 1'b0); step();
            check_eq($sformatf("t3_chk_b%0d", b),
                     32'({chk_skip, chk_exp_data, chk_act_data}), 32'b011);
            check_eq($sformatf("t3_inflight_b%0d", b), 32'(inflight),     (b < 4) ? 32'h4 : 32'h0);
            check_eq($sformatf("t3_cnt_b%0d", b),      32'(inflight_cnt), (b < 4) ? 32'd1 : 32'd0);
        end
        step();
        check_eq("t3_idle_skip", 32'(chk_skip),     32'd1);
        check_eq("t3_idle_hold", 32'(chk_exp_data), 32'd1);
        check_eq("t3_no_unk",    32'(err_unk_src),  32'd0);

        // D on idle src3, denied
        drive_d(2'd3, 1'b1, 1'b1, 1'b1); step();
        check_eq("t4_unk", 32'(err_unk_src), 32'd1);
        check_eq("t4_chk", 32'({chk_skip, chk_exp_data, chk_act_data, chk_bypass}), 32'b0011);
        check_eq("t4_inflight", 32'(inflight), 32'h0);

        // Fill all sources: exp = {src3:0, src2:1, src1:0, src0:1}
        drive_a(2'd0, 1'b1); step();
        drive_a(2'd1, 1'b0); step();
        drive_a(2'd2, 1'b1); step();
        drive_a(2'd3, 1'b0); step();
        check_eq("t5_full_cnt",      32'(inflight_cnt), 32'd4);
        check_eq("t5_full_inflight", 32'(inflight),     32'hF);

        // Same-cycle release + reallocate of src2 (new exp=0); check uses old exp=1
        drive_d(2'd2, 1'b1, 1'b1, 1'b0);
        drive_a(2'd2, 1'b0);
        step();
        check_eq("t5_swap_cnt",  32'(inflight_cnt), 32'd4);
        check_eq("t5_swap_infl", 32'(inflight),     32'hF);
        check_eq("t5_swap_dup",  32'(err_dup_src),  32'd0);
        check_eq("t5_swap_chk",  32'({chk_skip, chk_exp_data, chk_act_data}), 32'b011);

        // New exp for src2 is 0
        drive_d(2'd2, 1'b0, 1'b1, 1'b0); step();
        check_eq("t5_new_exp", 32'({chk_exp_data, chk_act_data}), 32'b00);
        check_eq("t5_rel_cnt", 32'(inflight_cnt), 32'd3);

        drive_a(2'd0, 1'b0); step();
        check_eq("t5_dup",     32'(err_dup_src),  32'd1);
        check_eq("t5_dup_cnt", 32'(inflight_cnt), 32'd3);

        // Mid-burst reset with 3 busy (src0,1,3)
        drive_d(2'd1, 1'b0, 1'b0, 1'b0); step();
        check_eq("t6_pre_infl", 32'(inflight), 32'hB);
        reset = 1;
        step();
        check_eq("t6_infl",   32'(inflight),     32'h0);
        check_eq("t6_cnt",    32'(inflight_cnt), 32'd0);
        check_eq("t6_skip",   32'(chk_skip),     32'd1);
        check_eq("t6_bypass", 32'(chk_bypass),   32'd1);
        check_eq("t6_errs",   32'({err_dup_src, err_unk_src}), 32'd0);
        reset = 0;
        step();
        drive_d(2'd1, 1'b1, 1'b1, 1'b0); step();
        check_eq("t6_dropped_unk", 32'(err_unk_src), 32'd1);
        check_eq("t6_dropped_exp", 32'({chk_exp_data, chk_act_data}), 32'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
